// File: rtl/sysbus_pkg.sv
// Shared definitions for the system-bus memory responder: tag encoding,
// responder states and byte-address to line-index mapping helpers.
package sysbus_pkg;

  localparam int unsigned TAG_WRITE_BIT  = 12;
  localparam int unsigned BYTE_SHIFT     = 3;   // one beat = one 8-byte word
  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_TAG_WIDTH  = 13;
  localparam int unsigned DEF_MEM_WORDS  = 4096;
  localparam int unsigned DEF_BURST_LEN  = 8;
  localparam int unsigned DEF_READ_LAT   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RLAT  = 2'd2,
    RRESP = 2'd3
  } state_e;

  // Lowest byte-address bit that selects a line (word shift + beat index bits).
  function automatic int unsigned line_lsb(input int unsigned burst_len);
    return BYTE_SHIFT + $clog2(burst_len);
  endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing store for the responder: synchronous write, combinational read,
// contents deliberately left unreset so they survive a bus reset.
module sysbus_mem_array #(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = 12
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side responder of the system bus: accepts a header beat, then either
// absorbs a write line or returns a read line with the request tag echoed.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUS_TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int unsigned MEM_WORDS      = DEF_MEM_WORDS,
  parameter int unsigned BURST_LEN      = DEF_BURST_LEN,
  parameter int unsigned READ_LATENCY   = DEF_READ_LAT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  output logic                      bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam int unsigned BEAT_W   = $clog2(BURST_LEN);
  localparam int unsigned LINE_W   = IDX_W - BEAT_W;
  localparam int unsigned LINE_LSB = line_lsb(BURST_LEN);
  localparam int unsigned LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_e                     r_state, w_state_nxt;
  logic [LINE_W-1:0]          r_line,  w_line_nxt;
  logic [BEAT_W-1:0]          r_beat,  w_beat_nxt;
  logic [LAT_W-1:0]           r_lat,   w_lat_nxt;
  logic [BUS_TAG_WIDTH-1:0]   r_tag,   w_tag_nxt;
  logic                       w_mem_we;
  logic                       w_req_xfer;
  logic                       w_last_beat;
  logic [IDX_W-1:0]           w_mem_addr;
  logic [BUS_DATA_WIDTH-1:0]  w_rdata;

  // Line index drops the beat bits so bursts always start at beat 0; the
  // upper address bits beyond the array simply fall away (modulo wrap).
  assign w_mem_addr  = {r_line, r_beat};
  assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
  assign bus_reqack  = reset && ((r_state == IDLE) || (r_state == WDATA));
  assign w_req_xfer  = bus_reqcyc && bus_reqack;
  assign bus_respcyc = (r_state == RRESP);
  assign bus_resp    = bus_respcyc ? w_rdata : '0;
  assign bus_resptag = bus_respcyc ? r_tag   : '0;

  sysbus_mem_array #(
    .WORDS (MEM_WORDS),
    .WIDTH (BUS_DATA_WIDTH),
    .AW    (IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (bus_req),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_beat  <= w_beat_nxt;
      r_lat   <= w_lat_nxt;
      r_tag   <= w_tag_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_beat_nxt  = r_beat;
    w_lat_nxt   = r_lat;
    w_tag_nxt   = r_tag;
    w_mem_we    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_xfer) begin
          w_line_nxt = bus_req[LINE_LSB +: LINE_W];
          w_tag_nxt  = bus_reqtag;
          w_beat_nxt = '0;
          if (bus_reqtag[TAG_WRITE_BIT]) begin
            w_state_nxt = WDATA;
          end else begin
            w_state_nxt = RLAT;
            w_lat_nxt   = LAT_W'(READ_LATENCY - 1);
          end
        end
      end
      WDATA: begin
        if (w_req_xfer) begin
          w_mem_we   = 1'b1;
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (w_last_beat) begin
            w_state_nxt = IDLE;
          end
        end
      end
      RLAT: begin
        if (r_lat == '0) begin
          w_state_nxt = RRESP;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      RRESP: begin
        if (bus_respack) begin
          w_beat_nxt = r_beat + BEAT_W'(1);
          if (w_last_beat) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: a table of write/read line
// transactions plus hand-written stall, hold-off and mid-burst reset cases.
module tb_sysbus_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_reqcyc = 1'b0;
  logic        bus_reqack;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_respcyc;
  logic        bus_respack = 1'b0;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sysbus_mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .bus_reqcyc  (bus_reqcyc),
    .bus_reqack  (bus_reqack),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_respcyc (bus_respcyc),
    .bus_respack (bus_respack),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag)
  );

  typedef struct {
    logic        is_wr;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] seed;   // write data base, or expected read data base
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one request-channel beat and hold it until it transfers.
  task automatic put_beat(input logic [63:0] d, input logic [12:0] t);
    int waited;
    waited = 0;
    @(negedge clk);
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    while (!bus_reqack && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_accept", 64'(bus_reqack), 64'd1);
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b0;
  endtask

  // Follow a read from its acceptance edge: latency, beats, optional stall/abort.
  task automatic collect(input logic [12:0] tag, input logic [63:0] seed,
                         input int stall_beat, input int abort_beat);
    @(negedge clk); check("lat_1", 64'(bus_respcyc), 64'd0);
    @(negedge clk); check("lat_2", 64'(bus_respcyc), 64'd0);
    @(negedge clk); check("lat_3", 64'(bus_respcyc), 64'd1);
    for (int b = 0; b < 8; b++) begin
      if (b == abort_beat) begin
        reset = 1'b0;
        #1;
        check("rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("rst_resp",    bus_resp,         64'd0);
        check("rst_resptag", 64'(bus_resptag), 64'd0);
        check("rst_reqack",  64'(bus_reqack),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_idle_ack", 64'(bus_reqack), 64'd1);
        check("rst_no_resp",  64'(bus_respcyc), 64'd0);
        return;
      end
      if (b == stall_beat) begin
        for (int s = 0; s < 5; s++) begin
          check("stall_data", bus_resp, seed + 64'(b));
          check("stall_tag",  64'(bus_resptag), 64'(tag));
          check("stall_cyc",  64'(bus_respcyc), 64'd1);
          @(negedge clk);
        end
      end
      check("rd_cyc",  64'(bus_respcyc), 64'd1);
      check("rd_data", bus_resp, seed + 64'(b));
      check("rd_tag",  64'(bus_resptag), 64'(tag));
      bus_respack = 1'b1;
      @(posedge clk);
      #1;
      bus_respack = 1'b0;
      if (b < 7) @(negedge clk);
    end
    @(negedge clk);
    check("end_respcyc", 64'(bus_respcyc), 64'd0);
    check("end_reqack",  64'(bus_reqack),  64'd1);
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] seed);
    put_beat(addr, tag);
    for (int b = 0; b < 8; b++) begin
      put_beat(seed + 64'(b), tag);
    end
    @(negedge clk);
    check("wr_no_resp", 64'(bus_respcyc), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h0040, 13'h1000, 64'h0};
    vecs[1] = '{1'b0, 64'h0047, 13'h0005, 64'h0};
    vecs[2] = '{1'b1, 64'h8000, 13'h1003, 64'h1111_0000_0000_0000};
    vecs[3] = '{1'b0, 64'h0000, 13'h0007, 64'h1111_0000_0000_0000};
    vecs[4] = '{1'b1, 64'h01F8, 13'h1ABC, 64'h2222_0000_0000_0010};
    vecs[5] = '{1'b0, 64'h01C0, 13'h0ABC, 64'h2222_0000_0000_0010};
    vecs[6] = '{1'b0, 64'h0044, 13'h0001, 64'h0};
    vecs[7] = '{1'b1, 64'h7FF8, 13'h1FFF, 64'h3333_0000_0000_0100};
    vecs[8] = '{1'b0, 64'hFFC0, 13'h0FFF, 64'h3333_0000_0000_0100};

    // Reset held for three cycles, outputs quiet throughout.
    repeat (3) begin
      @(negedge clk);
      check("rst_reqack",  64'(bus_reqack),  64'd0);
      check("rst_respcyc", 64'(bus_respcyc), 64'd0);
      check("rst_resp",    bus_resp,         64'd0);
      check("rst_resptag", 64'(bus_resptag), 64'd0);
    end
    reset = 1'b1;
    #1;
    check("idle_reqack", 64'(bus_reqack), 64'd1);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) begin
        write_line(vecs[i].addr, vecs[i].tag, vecs[i].seed);
      end else begin
        put_beat(vecs[i].addr, vecs[i].tag);
        collect(vecs[i].tag, vecs[i].seed, -1, -1);
      end
    end

    // Response back-pressure: beat 3 held for five cycles.
    put_beat(64'h0040, 13'h0015);
    collect(13'h0015, 64'h0, 3, -1);

    // Second request held on the bus while the first read is in flight;
    // respack is held high from acceptance, so it is ignored during latency.
    put_beat(64'h01C0, 13'h0011);
    @(negedge clk);
    bus_reqcyc  = 1'b1;
    bus_req     = 64'h0000;
    bus_reqtag  = 13'h0012;
    bus_respack = 1'b1;
    check("hold_ack_l1", 64'(bus_reqack),  64'd0);
    check("hold_cyc_l1", 64'(bus_respcyc), 64'd0);
    @(negedge clk);
    check("hold_ack_l2", 64'(bus_reqack),  64'd0);
    check("hold_cyc_l2", 64'(bus_respcyc), 64'd0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      check("hold_ack_rd", 64'(bus_reqack), 64'd0);
      check("hold_data",   bus_resp, 64'h2222_0000_0000_0010 + 64'(b));
      check("hold_tag",    64'(bus_resptag), 64'h0011);
    end
    @(negedge clk);
    bus_respack = 1'b0;
    check("turn_ack", 64'(bus_reqack),  64'd1);
    check("turn_cyc", 64'(bus_respcyc), 64'd0);
    @(posedge clk);
    #1;
    bus_reqcyc = 1'b0;
    collect(13'h0012, 64'h1111_0000_0000_0000, -1, -1);

    // Reset during beat 4 aborts the read; the next read is a full line.
    put_beat(64'hFFC0, 13'h0033);
    collect(13'h0033, 64'h3333_0000_0000_0100, -1, 4);
    repeat (2) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(bus_respcyc), 64'd0);
    end
    put_beat(64'hFFC0, 13'h0034);
    collect(13'h0034, 64'h3333_0000_0000_0100, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
